// File: rtl/muldiv_unit_if.sv
// Request/response bundle for muldiv_unit: operation request in, busy/done/result out.
// The slave modport is the unit side; the master modport is the requester side.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            StartE;
    logic [2:0]      funct3;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            FlushE;
    logic            BusyE;
    logic            DoneE;
    logic [XLEN-1:0] ResultE;

    modport master (
        output StartE, funct3, SrcAE, SrcBE, FlushE,
        input  BusyE, DoneE, ResultE
    );

    modport slave (
        input  StartE, funct3, SrcAE, SrcBE, FlushE,
        output BusyE, DoneE, ResultE
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV-style multiply/divide unit (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]      state;
    logic [CW-1:0]   count;
    logic [2:0]      op;
    logic [XLEN-1:0] hi, lo, mag;
    logic            neg_a, neg_b;
    logic [XLEN-1:0] result;

    logic            a_signed, b_signed, sa, sb, is_div, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [XLEN-1:0] hi_step, lo_step, final_res;

    // Magnitude product plus the sign correction, then pick the low or high half.
    function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p,
                                                 input logic neg, input logic [2:0] f);
        logic [2*XLEN-1:0] s;
        s = neg ? -p : p;
        return (f[1:0] == 2'b00) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
    endfunction

    always_comb begin
        is_div   = bus.funct3[2];
        a_signed = is_div ? !bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
        b_signed = is_div ? !bus.funct3[0] : !bus.funct3[1];
        sa       = a_signed & bus.SrcAE[XLEN-1];
        sb       = b_signed & bus.SrcBE[XLEN-1];
        a_mag    = sa ? -bus.SrcAE : bus.SrcAE;
        b_mag    = sb ? -bus.SrcBE : bus.SrcBE;
        div_zero = is_div && (bus.SrcBE == '0);
        div_ovf  = is_div && !bus.funct3[0] && (bus.SrcAE == MIN) && (bus.SrcBE == '1);
        if (div_zero)
            special = bus.funct3[1] ? bus.SrcAE : '1;
        else
            special = bus.funct3[1] ? '0 : MIN;
    end

    // One iteration step; MUL shifts {hi,lo} right, DIV shifts the dividend into hi.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag};
        if (state == MUL) begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            hi_step = div_diff[XLEN-1:0];
            lo_step = {lo[XLEN-2:0], 1'b1};
        end else begin
            hi_step = div_shift[XLEN-1:0];
            lo_step = {lo[XLEN-2:0], 1'b0};
        end
        if (state == MUL)
            final_res = mul_pick({hi_step, lo_step}, neg_a ^ neg_b, op);
        else if (op[1])
            final_res = neg_a ? -hi_step : hi_step;
        else
            final_res = (neg_a ^ neg_b) ? -lo_step : lo_step;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    always_comb fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            count  <= '0;
            op     <= '0;
            hi     <= '0;
            lo     <= '0;
            mag    <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            result <= '0;
        end else if (bus.FlushE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.StartE) begin
                        op    <= bus.funct3;
                        neg_a <= sa;
                        neg_b <= sb;
                        count <= '0;
                        if (div_zero || div_ovf) begin
                            result <= special;
                            state  <= DONE;
                        end else if (is_div) begin
                            hi    <= '0;
                            lo    <= a_mag;
                            mag   <= b_mag;
                            state <= DIV;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            result <= mul_pick(fast_prod, sa ^ sb, bus.funct3);
                            state  <= DONE;
`else
                            hi    <= '0;
                            lo    <= b_mag;
                            mag   <= a_mag;
                            state <= MUL;
`endif
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL, DIV: begin
                    hi <= hi_step;
                    lo <= lo_step;
                    if (count == LAST) begin
                        result <= final_res;
                        state  <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.BusyE   = (state == MUL) || (state == DIV);
    assign bus.DoneE   = (state == DONE);
    assign bus.ResultE = result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner-case sequences,
// and random operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();
    muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                q = ia / ib;
                return q;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                q = ia % ib;
                return q;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!f[2]) return MUL_LAT;
        if (b == 32'd0) return 1;
        if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return XLEN + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; holds StartE across one rising edge (cycle 0), returns in cycle 1.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.StartE = 1'b1;
        bus.funct3 = f;
        bus.SrcAE  = a;
        bus.SrcBE  = b;
        @(negedge clk);
        bus.StartE = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy, output logic [31:0] res);
        lat  = 1;
        busy = 0;
        while (!bus.DoneE && lat < 200) begin
            if (bus.BusyE) busy++;
            @(negedge clk);
            lat++;
        end
        res = bus.ResultE;
        if (!bus.DoneE) lat = -1;
    endtask

    task automatic run_check(input string name, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_res);
        int          lat, busy, el;
        logic [31:0] res;
        issue(f, a, b);
        wait_done(lat, busy, res);
        el = exp_lat(f, a, b);
        check({name, ".result"}, res, exp_res);
        check({name, ".latency"}, 32'(lat), 32'(el));
        check({name, ".busy_cycles"}, 32'(busy), 32'(el - 1));
        check({name, ".busy_in_done"}, {31'b0, bus.BusyE}, 32'd0);
        @(negedge clk);
        check({name, ".done_one_cycle"}, {31'b0, bus.DoneE}, 32'd0);
    endtask

    vec_t vecs[14];

    initial begin
        int          lat, busy, dcount, bcount, done_seen;
        logic [31:0] res, prev, ra, rb;
        logic [2:0]  rf;

        vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14};
        vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2};
        vecs[8]  = '{3'd4, 32'h1234,     32'd0,        32'hFFFFFFFF};
        vecs[9]  = '{3'd6, 32'h1234,     32'd0,        32'h1234};
        vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0};
        vecs[12] = '{3'd5, 32'd77,       32'd0,        32'hFFFFFFFF};
        vecs[13] = '{3'd7, 32'd5,        32'd0,        32'd5};

        bus.StartE = 1'b0;
        bus.FlushE = 1'b0;
        bus.funct3 = 3'd0;
        bus.SrcAE  = '0;
        bus.SrcBE  = '0;
        reset_n    = 1'b0;
        #1;
        check("reset.busy",   {31'b0, bus.BusyE}, 32'd0);
        check("reset.done",   {31'b0, bus.DoneE}, 32'd0);
        check("reset.result", bus.ResultE,        32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // First request is issued straight after release: must be taken on the first rising edge.
        for (int i = 0; i < 14; i++)
            run_check($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].res);

        // Flush with a simultaneous start: start dropped, no done, result held.
        prev = bus.ResultE;
        issue(3'd5, 32'd1000, 32'd3);
        done_seen = 0;
        for (int c = 1; c < 10; c++) begin
            if (bus.DoneE) done_seen = 1;
            @(negedge clk);
        end
        bus.FlushE = 1'b1;
        bus.StartE = 1'b1;
        bus.funct3 = 3'd0;
        bus.SrcAE  = 32'd5;
        bus.SrcBE  = 32'd6;
        @(negedge clk);
        bus.FlushE = 1'b0;
        bus.StartE = 1'b0;
        check("flush.no_done_before", 32'(done_seen), 32'd0);
        check("flush.c11_busy",   {31'b0, bus.BusyE}, 32'd0);
        check("flush.c11_done",   {31'b0, bus.DoneE}, 32'd0);
        check("flush.c11_result", bus.ResultE,        prev);
        @(negedge clk);
        check("flush.c12_busy",   {31'b0, bus.BusyE}, 32'd0);
        check("flush.c12_done",   {31'b0, bus.DoneE}, 32'd0);
        run_check("flush.restart", 3'd5, 32'd1000, 32'd3, 32'd333);

        // StartE while dividing is ignored.
        issue(3'd5, 32'd1000, 32'd7);
        repeat (4) @(negedge clk);
        bus.StartE = 1'b1;
        bus.funct3 = 3'd0;
        bus.SrcAE  = 32'd3;
        bus.SrcBE  = 32'd3;
        @(negedge clk);
        bus.StartE = 1'b0;
        wait_done(lat, busy, res);
        check("ignore.result",  res,          32'd142);
        check("ignore.latency", 32'(lat + 5), 32'd33);
        @(negedge clk);

        // Asynchronous reset in the middle of a divide.
        issue(3'd4, 32'hFFFF0000, 32'd3);
        repeat (4) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid.busy",   {31'b0, bus.BusyE}, 32'd0);
        check("rst_mid.done",   {31'b0, bus.DoneE}, 32'd0);
        check("rst_mid.result", bus.ResultE,        32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        dcount = 0;
        bcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.DoneE) dcount++;
            if (bus.BusyE) bcount++;
        end
        check("rst_mid.no_done_after", 32'(dcount), 32'd0);
        check("rst_mid.no_busy_after", 32'(bcount), 32'd0);

        // Back-to-back: second request issued in the DONE cycle of the first.
        issue(3'd5, 32'd5000, 32'd9);
        wait_done(lat, busy, res);
        check("b2b.first_result",  res,        32'd555);
        check("b2b.first_latency", 32'(lat),   32'd33);
        issue(3'd7, 32'd5000, 32'd9);
        wait_done(lat, busy, res);
        check("b2b.second_result", res,        32'd5);
        check("b2b.done_gap",      32'(lat),   32'd33);
        @(negedge clk);
        check("b2b.done_one_cycle", {31'b0, bus.DoneE}, 32'd0);

        // Random operations against the reference model, with divisor/dividend corners mixed in.
        for (int i = 0; i < 150; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_check($sformatf("rand%0d", i), rf, ra, rb, model(rf, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter XLEN SHALL default to 32 and sets the operand/result width; legal values are even and >= 8.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the rising-edge clock.
REQ-004 Port reset_n SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-005 Port StartE SHALL be an input, 1 bit wide, and requests a new operation.
REQ-006 Port funct3 SHALL be an input, 3 bits wide, and selects the operation: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-007 Port SrcAE SHALL be an input, XLEN bits wide, and carries the multiplicand or dividend.
REQ-008 Port SrcBE SHALL be an input, XLEN bits wide, and carries the multiplier or divisor.
REQ-009 Port FlushE SHALL be an input, 1 bit wide, and aborts the operation in flight.
REQ-010 Port BusyE SHALL be an output, 1 bit wide, and is high while an accepted operation has not completed.
REQ-011 Port DoneE SHALL be an output, 1 bit wide, and is a one-cycle pulse that marks ResultE valid.
REQ-012 Port ResultE SHALL be an output, XLEN bits wide, and carries the registered result.

Function
REQ-013 The FSM SHALL have the states IDLE, MUL, DIV and DONE.
REQ-014 StartE SHALL be accepted only in IDLE or DONE; funct3, SrcAE and SrcBE are captured on that clock edge (the acceptance cycle is cycle 0).
REQ-015 StartE SHALL be ignored while in the MUL or DIV state.
REQ-016 mul SHALL return the low XLEN bits of the product.
REQ-017 mulh, mulhsu and mulhu SHALL return the high XLEN bits of the 2*XLEN-bit product, treating the operands as signed×signed, signed×unsigned and unsigned×unsigned respectively.
REQ-018 Iterative multiply SHALL use shift-add over magnitudes with sign correction, remaining in MUL for cycles 1..XLEN.
REQ-019 Divide SHALL use restoring division over magnitudes, remaining in DIV for cycles 1..XLEN.
REQ-020 Quotient SHALL round toward zero, and the remainder sign SHALL equal the dividend sign.
REQ-021 On divide-by-zero, the quotient SHALL be all ones and the remainder SHALL equal SrcAE.
REQ-022 A divide-by-zero operation SHALL skip the DIV state and enter DONE at cycle 1.
REQ-023 On signed overflow (div/rem with SrcAE = most-negative and SrcBE = -1), the quotient SHALL be the most-negative value and the remainder SHALL be 0, with DONE at cycle 1.
REQ-024 An iterative operation SHALL hold DONE for exactly one cycle, at cycle XLEN+1, with DoneE=1 and ResultE valid.
REQ-025 BusyE SHALL be 1 in the MUL and DIV states and 0 in IDLE and DONE.
REQ-026 ResultE SHALL hold its value until the next DONE.
REQ-027 The iteration counter SHALL be $clog2(XLEN)+1 bits wide and wrap-free, loading 0 at Start and terminating at XLEN-1.
REQ-028 StartE in DONE SHALL be accepted (back-to-back operation), and that cycle is cycle 0 of the new operation.
REQ-029 FlushE SHALL force IDLE on the next edge with no DoneE pulse, and ResultE SHALL be unchanged.
REQ-030 FlushE SHALL take priority over a simultaneous StartE, which is dropped.
REQ-031 FlushE in IDLE SHALL have no effect.

Reset
REQ-032 When reset_n=0, the block SHALL immediately (asynchronously) enter IDLE with BusyE=0, DoneE=0, ResultE=0, the counter at 0 and internal operand/partial registers at 0.
REQ-033 Reset asserted mid-operation SHALL discard the operation, and no DoneE SHALL follow deassertion.
REQ-034 The first StartE SHALL be accepted on the first rising edge after reset_n rises.

Configuration
REQ-035 The macro MULDIV_FAST_MUL_EN SHALL select the multiply implementation.
REQ-036 With MULDIV_FAST_MUL_EN defined, mul, mulh, mulhsu and mulhu SHALL use a single-cycle 2*XLEN-bit combinational product, bypass the MUL state and reach DONE at cycle 1 with DoneE at cycle 1.
REQ-037 With MULDIV_FAST_MUL_EN undefined, multiply SHALL be iterative per REQ-018 with DoneE at cycle XLEN+1.
REQ-038 Divide timing SHALL be identical in both configurations.

Verification (XLEN=32)
REQ-039 mul 7 × 0xFFFFFFFD -> ResultE=0xFFFFFFEB with DoneE at cycle 33 (MULDIV_FAST_MUL_EN undefined) or cycle 1 (defined), and BusyE high during cycles 1-32 when iterative.
REQ-040 mulh 0x80000000 × 0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-041 div 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, and rem -> 0xFFFFFFFF, with DoneE at cycle 33; divu 100 / 7 -> 14 and remu -> 2.
REQ-042 div 0x1234 / 0 -> 0xFFFFFFFF and rem -> 0x1234, each with DoneE at cycle 1; div 0x80000000 / 0xFFFFFFFF -> 0x80000000 and rem -> 0, each with DoneE at cycle 1.
REQ-043 Start divu, then FlushE at cycle 10 with StartE also high -> IDLE at cycle 11, no DoneE, ResultE unchanged; a new StartE at cycle 12 is accepted and completes correctly.
REQ-044 Start div, then pull reset_n low at cycle 5 -> BusyE=0 and ResultE=0 immediately, and no DoneE after release; two back-to-back divu operations, with the second started in the DONE cycle, produce two DoneE pulses 33 cycles apart.
